// File: rtl/vec_accel_pkg.sv
// Shared types for the vector accelerator slice: load-buffer FSM state,
// reduction op select, and the lane-counter width helper.
package vec_accel_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } vlb_state_t;

  typedef logic [1:0] red_op_t;

  // Lane counter width; a single-bit counter is kept as the floor.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vector_load_buffer.sv
// Assembles a valid/ready element stream into an N-lane vector, pulses set_out
// to the ALU and holds the vector until alu_done. Optional sticky protocol-error
// detection is built only with VECTOR_LOAD_BUFFER_ERR_EN defined.
module vector_load_buffer
  import vec_accel_pkg::*;
#(
  parameter int unsigned     BITS = 8,
  parameter int unsigned     N    = 4,
  parameter logic [BITS-1:0] PAD  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] s_data,
  input  logic            s_valid,
  input  logic            s_last,
  input  logic [1:0]      s_op,
  output logic            s_ready,
  output logic [BITS-1:0] vec_out [N-1:0],
  output logic [1:0]      sel_out,
  output logic            set_out,
  input  logic            alu_done,
  output logic            busy,
  output logic            err
);

  localparam int unsigned CW = cnt_width(N);

  vlb_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  red_op_t         sel_q, sel_d;
  logic [BITS-1:0] vec_q [N-1:0];
  logic [BITS-1:0] vec_d [N-1:0];
  logic            accept;
  logic            last_lane;

  assign accept    = (state_q == FILL) && s_valid;
  assign last_lane = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    vec_d   = vec_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          // Lanes above the current one are padded when the vector ends early.
          for (int unsigned k = 0; k < N; k++) begin
            if (k == 32'(cnt_q))
              vec_d[k] = s_data;
            else if (s_last && (k > 32'(cnt_q)))
              vec_d[k] = PAD;
          end
          if (cnt_q == '0)
            sel_d = s_op;
          if (last_lane || s_last) begin
            state_d = ISSUE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (alu_done) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      sel_q   <= '0;
      vec_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      vec_q   <= vec_d;
    end
  end

  // Outputs are gated by rst_n so they read idle while reset is held.
  assign s_ready = rst_n && (state_q == FILL);
  assign busy    = rst_n && ((state_q == ISSUE) || (state_q == WAIT));
  assign set_out = rst_n && (state_q == ISSUE);
  assign sel_out = sel_q;
  assign vec_out = vec_q;

`ifdef VECTOR_LOAD_BUFFER_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (accept && last_lane && !s_last)
      err_d = 1'b1;
    if (alu_done && (state_q != WAIT))
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vector_load_buffer.sv
// Directed self-checking bench for vector_load_buffer (N=4, BITS=8, PAD=0).
module tb_vector_load_buffer;

  localparam int unsigned BITS = 8;
  localparam int unsigned N    = 4;
`ifdef VECTOR_LOAD_BUFFER_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [BITS-1:0] s_data;
  logic            s_valid;
  logic            s_last;
  logic [1:0]      s_op;
  logic            s_ready;
  logic [BITS-1:0] vec_out [N-1:0];
  logic [1:0]      sel_out;
  logic            set_out;
  logic            alu_done;
  logic            busy;
  logic            err;

  int checks   = 0;
  int failures = 0;

  vector_load_buffer #(.BITS(BITS), .N(N), .PAD(8'h00)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_op     (s_op),
    .s_ready  (s_ready),
    .vec_out  (vec_out),
    .sel_out  (sel_out),
    .set_out  (set_out),
    .alu_done (alu_done),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_lanes(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
    chk({tag, ".lane0"}, 32'(vec_out[0]), 32'(e0));
    chk({tag, ".lane1"}, 32'(vec_out[1]), 32'(e1));
    chk({tag, ".lane2"}, 32'(vec_out[2]), 32'(e2));
    chk({tag, ".lane3"}, 32'(vec_out[3]), 32'(e3));
  endtask

  task automatic beat(input logic [7:0] d, input logic [1:0] op, input logic last);
    s_data  = d;
    s_op    = op;
    s_last  = last;
    s_valid = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; s_op = '0; alu_done = 1'b0;
    #1;
    tick(); tick();
    chk("rst.s_ready", 32'(s_ready), 32'd0);
    chk("rst.busy",    32'(busy),    32'd0);
    chk("rst.set_out", 32'(set_out), 32'd0);
    chk("rst.err",     32'(err),     32'd0);
    chk("rst.sel_out", 32'(sel_out), 32'd0);
    chk_lanes("rst", 8'h00, 8'h00, 8'h00, 8'h00);

    rst_n = 1'b1;
    tick();
    chk("post_rst.s_ready", 32'(s_ready), 32'd1);
    chk("post_rst.busy",    32'(busy),    32'd0);

    // Full vector; op on later beats must be ignored.
    beat(8'h04, 2'b01, 1'b0);
    beat(8'h40, 2'b11, 1'b0);
    beat(8'h12, 2'b10, 1'b0);
    beat(8'h03, 2'b11, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    chk("full.set_out", 32'(set_out), 32'd1);
    chk("full.busy",    32'(busy),    32'd1);
    chk("full.s_ready", 32'(s_ready), 32'd0);
    chk("full.sel_out", 32'(sel_out), 32'h1);
    chk("full.err",     32'(err),     32'd0);
    chk_lanes("full", 8'h04, 8'h40, 8'h12, 8'h03);
    tick();
    chk("full.wait.set_out", 32'(set_out), 32'd0);
    chk("full.wait.busy",    32'(busy),    32'd1);
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    chk("full.rel.s_ready", 32'(s_ready), 32'd1);
    chk("full.rel.busy",    32'(busy),    32'd0);
    chk("full.rel.err",     32'(err),     32'd0);

    // Short vector padded with PAD.
    beat(8'hAA, 2'b10, 1'b0);
    chk("short.mid.set_out", 32'(set_out), 32'd0);
    beat(8'hBB, 2'b00, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    chk("short.set_out", 32'(set_out), 32'd1);
    chk("short.sel_out", 32'(sel_out), 32'h2);
    chk_lanes("short", 8'hAA, 8'hBB, 8'h00, 8'h00);
    tick();

    // Backpressure: beat held in WAIT must not land.
    s_data = 8'h5C; s_op = 2'b00; s_last = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp.s_ready", 32'(s_ready), 32'd0);
      chk("bp.set_out", 32'(set_out), 32'd0);
      chk("bp.lane0",   32'(vec_out[0]), 32'hAA);
    end
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    chk("bp.rel.s_ready", 32'(s_ready), 32'd1);
    chk("bp.rel.lane0",   32'(vec_out[0]), 32'hAA);
    tick();
    chk("bp.land.lane0",   32'(vec_out[0]), 32'h5C);
    chk("bp.land.lane1",   32'(vec_out[1]), 32'hBB);
    chk("bp.land.sel_out", 32'(sel_out),    32'h0);
    chk("bp.land.s_ready", 32'(s_ready),    32'd1);
    beat(8'h11, 2'b11, 1'b0);
    beat(8'h22, 2'b11, 1'b0);
    beat(8'h33, 2'b11, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    chk("bp.vec.set_out", 32'(set_out), 32'd1);
    chk_lanes("bp.vec", 8'h5C, 8'h11, 8'h22, 8'h33);
    tick();
    chk("bp.vec.wait", 32'(busy), 32'd1);

    // Reset mid-WAIT aborts the vector.
    rst_n = 1'b0;
    tick();
    chk("rstw.set_out", 32'(set_out), 32'd0);
    chk("rstw.busy",    32'(busy),    32'd0);
    chk("rstw.s_ready", 32'(s_ready), 32'd0);
    chk_lanes("rstw", 8'h00, 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    tick();
    chk("rstw.rel.s_ready", 32'(s_ready), 32'd1);
    chk("rstw.rel.set_out", 32'(set_out), 32'd0);
    chk("rstw.rel.busy",    32'(busy),    32'd0);
    tick();
    chk("rstw.idle.set_out", 32'(set_out), 32'd0);

    // Missing s_last on the N-th beat: still issues, err per build.
    beat(8'h01, 2'b11, 1'b0);
    beat(8'h02, 2'b00, 1'b0);
    beat(8'h03, 2'b00, 1'b0);
    beat(8'h04, 2'b00, 1'b0);
    s_valid = 1'b0;
    chk("nolast.set_out", 32'(set_out), 32'd1);
    chk("nolast.sel_out", 32'(sel_out), 32'h3);
    chk("nolast.err",     32'(err),     32'(ERR_EXP));
    chk_lanes("nolast", 8'h01, 8'h02, 8'h03, 8'h04);
    tick();
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    chk("nolast.rel.s_ready", 32'(s_ready), 32'd1);

    // alu_done during FILL: ignored functionally, sticky err per build.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("donefill.pre.err", 32'(err), 32'd0);
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    chk("donefill.err",     32'(err),     32'(ERR_EXP));
    chk("donefill.s_ready", 32'(s_ready), 32'd1);
    chk("donefill.busy",    32'(busy),    32'd0);
    tick();
    chk("donefill.sticky", 32'(err), 32'(ERR_EXP));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vector_load_buffer.md
# vector_load_buffer

Upstream feeder for `reduce_vector_alu`. Accepts a stream of BITS-wide elements over a valid/ready handshake and assembles them into an N-lane vector. It then pulses `set_out` with the vector and its 2-bit op held stable, and blocks further input until the ALU reports `done`. It is the only block that drives the ALU's `in`, `sel` and `set` inputs.

## Interface
- `BITS`, 8: element width; must match the ALU.
- `N`, 4: lanes per vector; must be at least 2 and must match the ALU.
- `PAD`, 0: BITS-wide value written into lanes not supplied when a vector ends early.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `s_data`  in  BITS  element payload.
- `s_valid`  in  1  element offered.
- `s_last`  in  1  marks the final element of a vector.
- `s_op`  in  2  reduction select; captured with lane 0 only.
- `s_ready`  out  1  block can accept an element this cycle.
- `vec_out`  out  BITS x N (unpacked [N-1:0])  lane k = k-th accepted element.
- `sel_out`  out  2  captured op; drives ALU `sel`.
- `set_out`  out  1  one-cycle start pulse; drives ALU `set`.
- `alu_done`  in  1  ALU `done`.
- `busy`  out  1  high in ISSUE and WAIT.
- `err`  out  1  sticky protocol-error flag (see Configuration).

## Operation
- Three states: FILL, ISSUE, WAIT.
- **FILL**
  - `s_ready`=1. A beat is accepted when `s_valid && s_ready`.
  - The accepted element is written to lane `cnt`, then `cnt` increments.
  - `s_op` is written to `sel_out` when `cnt`==0.
- **FILL → ISSUE**
  - Taken on an accepted beat with `cnt`==N-1, or on an accepted beat with `s_last`=1.
  - On an early `s_last` (`cnt`<N-1), lanes `cnt`+1..N-1 are written with PAD in the same cycle.
  - `cnt` clears.
- **ISSUE**
  - `set_out`=1 for exactly this one cycle; `s_ready`=0.
  - Always goes to WAIT next cycle.
- **WAIT**
  - `s_ready`=0.
  - Leaves to FILL on the first cycle `alu_done`=1.
- **`alu_done` outside WAIT**: ignored, including during ISSUE.
- **Output stability**: `vec_out` and `sel_out` change only on FILL writes. They are stable from ISSUE until WAIT exits.
- **Missing `s_last`**: if `s_last`=0 on the N-th beat, the vector still issues; extra elements are never buffered.
- **`s_valid` while `s_ready`=0**: no beat is taken; the source must hold the beat.
- **Reset**
  - State goes to FILL, `cnt`=0, all lanes 0, `sel_out`=0, `set_out`=0, `err`=0.
  - During reset, `s_ready`=0 and `busy`=0.
  - Reset asserted mid-ISSUE or mid-WAIT aborts the vector; no `set_out` is produced afterward.

## Timing
- `s_ready` and `busy` are decoded from the registered state; there is no combinational path from `s_valid`.
- **After reset**: `s_ready`=1 on the first cycle after `rst_n` samples high.
- **Issue latency**: a final beat accepted at edge t gives `set_out`=1 in cycle t+1 and `busy`=1 from cycle t+1.
- **Release latency**: `alu_done` sampled at edge d gives `s_ready`=1 and `busy`=0 in cycle d+1.
- **Throughput**: at most one vector per N + 2 + ALU-latency cycles.

## Configuration
- Macro: `VECTOR_LOAD_BUFFER_ERR_EN`.
- **With the macro**, `err` is set, and held until reset, on either of:
  - `s_last`=0 on the N-th accepted beat;
  - `alu_done`=1 while the state is not WAIT.
- Function is otherwise unchanged; errors never stall or drop data.
- **Without the macro**, `err` is tied to 0 and no error logic is built. The port list is identical in both builds.

## Structure
- Shared package `vec_accel_pkg`:
  - `vlb_state_t` enum {FILL, ISSUE, WAIT};
  - `red_op_t` typedef, logic [1:0];
  - counter width `$clog2(N)`, expressed as a localparam function.
- Single flat module; no sub-module is warranted. The lane array is a plain register array written by decoded index.

## Test plan
- **Full vector**: N=4, BITS=8, op 01; beats 04, 40, 12, 03 with `s_last` on 03. Expect `vec_out`[0..3]=04, 40, 12, 03, `sel_out`=01, `set_out` high one cycle after the 03 beat, `err`=0.
- **Short vector**: beats AA, BB with `s_last` on BB, PAD=00. Expect lanes = AA, BB, 00, 00 and `set_out` on the next cycle.
- **Backpressure**: hold `alu_done`=0 for 20 cycles while `s_valid`=1. Expect `s_ready`=0 and `vec_out` unchanged throughout. Pulse `alu_done`; expect `s_ready`=1 the next cycle and the held beat to land in lane 0.
- **Reset mid-WAIT**: assert `rst_n`=0 for one cycle. Expect all lanes 0, `set_out`=0, `busy`=0; `s_ready`=1 in the cycle after release.
- **Errors, ERR_EN build**:
  - send 4 beats with no `s_last` → `err`=1 and the vector still issues;
  - `alu_done` during FILL → `err`=1.
- **Errors, non-ERR_EN build**: the same stimulus leaves `err`=0.
